// File: rtl/alu_dsp_stereo_if.sv
// Request/response bundle between an ALU sequencer and the stereo DSP MAC unit.
// Both lanes share one op word; each lane has its own A/B/C operands and P result.
interface alu_dsp_stereo_if #(
    parameter int AB_WIDTH = 18,
    parameter int P_WIDTH  = 48,
    parameter int OP_WIDTH = 9
);
    logic        [OP_WIDTH-1:0] dsp_op;
    logic signed [AB_WIDTH-1:0] dsp_al;
    logic signed [AB_WIDTH-1:0] dsp_bl;
    logic signed [P_WIDTH-1:0]  dsp_cl;
    logic signed [AB_WIDTH-1:0] dsp_ar;
    logic signed [AB_WIDTH-1:0] dsp_br;
    logic signed [P_WIDTH-1:0]  dsp_cr;
    logic signed [P_WIDTH-1:0]  dsp_pl;
    logic signed [P_WIDTH-1:0]  dsp_pr;
    logic                       p_valid;

    modport master (
        output dsp_op, dsp_al, dsp_bl, dsp_cl, dsp_ar, dsp_br, dsp_cr,
        input  dsp_pl, dsp_pr, p_valid
    );

    modport slave (
        input  dsp_op, dsp_al, dsp_bl, dsp_cl, dsp_ar, dsp_br, dsp_cr,
        output dsp_pl, dsp_pr, p_valid
    );
endinterface

// File: rtl/alu_dsp_stereo.sv
// Dual-lane 3-stage multiply/accumulate unit with DSP48A1-style X/Z post-adder.
// Left and right datapaths run in lockstep under one shared op/control pipeline.
module alu_dsp_stereo #(
    parameter int AB_WIDTH = 18,
    parameter int P_WIDTH  = 48,
    parameter int OP_WIDTH = 9
) (
    input logic            clk,
    input logic            reset_n,
    alu_dsp_stereo_if.slave dsp
);
    localparam int M_WIDTH = 2 * AB_WIDTH;
    localparam int N_LANES = 2;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_MULT = 2'd1,
        X_PIN  = 2'd2,
        X_RSVD = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PIN  = 2'd1,
        Z_CIN  = 2'd2,
        Z_RSVD = 2'd3
    } z_sel_e;

    // Shared control pipeline
    logic [OP_WIDTH-1:0] op1_q;
    logic [OP_WIDTH-1:0] op2_q;
    logic                valid_q;

    x_sel_e x_sel;
    z_sel_e z_sel;
    logic   post_sub;
    logic   p_en;

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op1_q   <= '0;
            op2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            op1_q   <= dsp.dsp_op;
            op2_q   <= op1_q;
            valid_q <= |op2_q;
        end
    end

    assign x_sel    = x_sel_e'(op2_q[1:0]);
    assign z_sel    = z_sel_e'(op2_q[3:2]);
    assign post_sub = op2_q[4];
    // An all-zero op is a bubble: P keeps its value at stage 3.
    assign p_en     = |op2_q;

    // Per-lane operand fan-in and result fan-out
    logic signed [AB_WIDTH-1:0] a_lane [N_LANES];
    logic signed [AB_WIDTH-1:0] b_lane [N_LANES];
    logic signed [P_WIDTH-1:0]  c_lane [N_LANES];
    logic signed [P_WIDTH-1:0]  p_lane [N_LANES];

    assign a_lane[0] = dsp.dsp_al;
    assign b_lane[0] = dsp.dsp_bl;
    assign c_lane[0] = dsp.dsp_cl;
    assign a_lane[1] = dsp.dsp_ar;
    assign b_lane[1] = dsp.dsp_br;
    assign c_lane[1] = dsp.dsp_cr;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        logic signed [AB_WIDTH-1:0] a_q;
        logic signed [AB_WIDTH-1:0] b_q;
        logic signed [P_WIDTH-1:0]  c1_q;
        logic signed [P_WIDTH-1:0]  c2_q;
        logic signed [P_WIDTH-1:0]  m_q;
        logic signed [P_WIDTH-1:0]  p_q;
        logic signed [P_WIDTH-1:0]  p_d;
        logic signed [M_WIDTH-1:0]  prod;
        logic signed [P_WIDTH-1:0]  x_val;
        logic signed [P_WIDTH-1:0]  z_val;

        assign prod = a_q * b_q;

        // NOTE: every combinational output gets a default first so no path
        // through the case statements can infer a latch.
        always_comb begin
            x_val = '0;
            z_val = '0;
            case (x_sel)
                X_MULT:  x_val = m_q;
                X_PIN:   x_val = p_q;
                default: x_val = '0;
            endcase
            case (z_sel)
                Z_PIN:   z_val = p_q;
                Z_CIN:   z_val = c2_q;
                default: z_val = '0;
            endcase
            p_d = post_sub ? (z_val - x_val) : (z_val + x_val);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                a_q  <= '0;
                b_q  <= '0;
                c1_q <= '0;
                m_q  <= '0;
                c2_q <= '0;
                p_q  <= '0;
            end else begin
                a_q  <= a_lane[l];
                b_q  <= b_lane[l];
                c1_q <= c_lane[l];
                m_q  <= {{(P_WIDTH - M_WIDTH){prod[M_WIDTH-1]}}, prod};
                c2_q <= c1_q;
                if (p_en) begin
                    p_q <= p_d;
                end
            end
        end

        assign p_lane[l] = p_q;
    end

    assign dsp.dsp_pl  = p_lane[0];
    assign dsp.dsp_pr  = p_lane[1];
    assign dsp.p_valid = valid_q;

endmodule

// File: tb/tb_alu_dsp_stereo.sv
// Scoreboard bench for alu_dsp_stereo: directed ops push hand-computed P values,
// a monitor pops and compares on every p_valid pulse.
module tb_alu_dsp_stereo;
    localparam logic [8:0] XM  = 9'h001;
    localparam logic [8:0] XP  = 9'h002;
    localparam logic [8:0] ZP  = 9'h004;
    localparam logic [8:0] ZC  = 9'h008;
    localparam logic [8:0] SUB = 9'h010;
    localparam logic [8:0] NOP = 9'h000;

    typedef struct {
        logic [47:0] pl;
        logic [47:0] pr;
    } exp_t;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];

    alu_dsp_stereo_if dsp_if ();

    alu_dsp_stereo dut (
        .clk    (clk),
        .reset_n(reset_n),
        .dsp    (dsp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] op,
                         input logic [17:0] al, input logic [17:0] bl, input logic [47:0] cl,
                         input logic [17:0] ar, input logic [17:0] br, input logic [47:0] cr);
        dsp_if.dsp_op = op;
        dsp_if.dsp_al = al;
        dsp_if.dsp_bl = bl;
        dsp_if.dsp_cl = cl;
        dsp_if.dsp_ar = ar;
        dsp_if.dsp_br = br;
        dsp_if.dsp_cr = cr;
    endtask

    task automatic issue(input logic [8:0] op,
                         input logic [17:0] al, input logic [17:0] bl, input logic [47:0] cl,
                         input logic [17:0] ar, input logic [17:0] br, input logic [47:0] cr,
                         input logic [47:0] el, input logic [47:0] er);
        exp_t e;
        @(negedge clk);
        drive(op, al, bl, cl, ar, br, cr);
        if (op != NOP) begin
            e.pl = el;
            e.pr = er;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(NOP, '0, '0, '0, '0, '0, '0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 48'(exp_q.size()), 48'd0);
    endtask

    // Monitor: every p_valid pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && dsp_if.p_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 48'd1, 48'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("p_left", dsp_if.dsp_pl, e.pl);
                    check("p_right", dsp_if.dsp_pr, e.pr);
                end
            end
        end
    end

    initial begin
        int lat;
        tests_run    = 0;
        tests_failed = 0;
        drive(NOP, '0, '0, '0, '0, '0, '0);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("reset_pl", dsp_if.dsp_pl, 48'd0);
        check("reset_pr", dsp_if.dsp_pr, 48'd0);
        check("reset_valid", 48'(dsp_if.p_valid), 48'd0);
        #9 reset_n = 1'b1;

        // Plain and signed multiplies, then multiply-add, issued back to back
        issue(XM, 18'h10000, 18'h08000, '0, 18'h00000, 18'h00000, '0,
              48'h0000_8000_0000, 48'h0000_0000_0000);
        issue(XM, 18'h30000, 18'h08000, '0, 18'h04000, 18'h04000, '0,
              48'hFFFF_8000_0000, 48'h0000_1000_0000);
        issue(XM | ZC, 18'h10000, 18'h10000, 48'h0000_0001_0000,
              18'h10000, 18'h30000, 48'h0000_0002_0000,
              48'h0001_0001_0000, 48'hFFFF_0002_0000);
        // Sub-only op with X=0, Z=0 clears P
        issue(SUB, '0, '0, '0, '0, '0, '0, 48'd0, 48'd0);
        // Accumulation chain at one op per cycle
        issue(XM | ZP, 18'h10000, 18'h04000, '0, 18'h30000, 18'h04000, '0,
              48'h0000_4000_0000, 48'hFFFF_C000_0000);
        issue(XM | ZP, 18'h10000, 18'h04000, '0, 18'h30000, 18'h04000, '0,
              48'h0000_8000_0000, 48'hFFFF_8000_0000);
        issue(XM | ZP, 18'h10000, 18'h04000, '0, 18'h30000, 18'h04000, '0,
              48'h0000_C000_0000, 48'hFFFF_4000_0000);
        issue(XM | ZP, 18'h10000, 18'h04000, '0, 18'h30000, 18'h04000, '0,
              48'h0001_0000_0000, 48'hFFFF_0000_0000);
        issue(NOP, 18'h10000, 18'h10000, 48'h1, 18'h10000, 18'h10000, 48'h1, '0, '0);
        repeat (3) @(negedge clk);
        check("nop_valid", 48'(dsp_if.p_valid), 48'd0);
        check("nop_hold_pl", dsp_if.dsp_pl, 48'h0001_0000_0000);
        check("nop_hold_pr", dsp_if.dsp_pr, 48'hFFFF_0000_0000);

        // Subtract, load C, doubling with wrap, self-subtract
        issue(XM | ZP | SUB, 18'h10000, 18'h10000, '0, 18'h10000, 18'h10000, '0,
              48'h0000_0000_0000, 48'hFFFE_0000_0000);
        issue(ZC, '0, '0, 48'h0000_0000_0003, '0, '0, 48'h7FFF_FFFF_FFFF,
              48'h0000_0000_0003, 48'h7FFF_FFFF_FFFF);
        issue(XP | ZP, '0, '0, '0, '0, '0, '0,
              48'h0000_0000_0006, 48'hFFFF_FFFF_FFFE);
        issue(XP | ZP | SUB, '0, '0, '0, '0, '0, '0, 48'd0, 48'd0);
        // Reserved encodings: X=3 reads zero, reserved op bits ignored, Z=3 reads zero
        issue(9'h11B, 18'h10000, 18'h10000, 48'h1234_5678_9ABC, 18'h10000, 18'h10000, 48'h1,
              48'h1234_5678_9ABC, 48'h0000_0000_0001);
        issue(9'h00D, 18'h08000, 18'h08000, 48'h5, 18'h3C000, 18'h10000, 48'h5,
              48'h0000_4000_0000, 48'hFFFF_C000_0000);
        issue(9'h0E0, '0, '0, 48'h5, '0, '0, 48'h5, 48'd0, 48'd0);
        issue(XM, 18'h10000, 18'h10000, '0, 18'h10000, 18'h10000, '0,
              48'h0001_0000_0000, 48'h0001_0000_0000);
        idle(1);
        drain();

        // Reset between stage-2 and stage-3 edges of two in-flight multiplies
        @(negedge clk);
        drive(XM, 18'h08000, 18'h10000, '0, 18'h08000, 18'h10000, '0);
        @(negedge clk);
        drive(XM, 18'h10000, 18'h10000, '0, 18'h10000, 18'h10000, '0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        drive(NOP, '0, '0, '0, '0, '0, '0);
        #1;
        check("midrst_pl", dsp_if.dsp_pl, 48'd0);
        check("midrst_pr", dsp_if.dsp_pr, 48'd0);
        check("midrst_valid", 48'(dsp_if.p_valid), 48'd0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 48'(dsp_if.p_valid), 48'd0);
        end
        check("post_rst_pl", dsp_if.dsp_pl, 48'd0);

        // Fresh multiply after reset: valid on the third falling edge after issue
        issue(XM, 18'h10000, 18'h08000, '0, 18'h04000, 18'h04000, '0,
              48'h0000_8000_0000, 48'h0000_1000_0000);
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            drive(NOP, '0, '0, '0, '0, '0, '0);
            if (dsp_if.p_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("post_rst_latency", 48'(lat), 48'd3);
        check("post_rst_pl_q", 48'(dsp_if.dsp_pl[33:16]), 48'h08000);
        @(negedge clk);
        check("single_pulse", 48'(dsp_if.p_valid), 48'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the bench always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_dsp_stereo.md
Name: alu_dsp_stereo

Overview:
- Responder end of the ALU DSP request interface: a dual-lane (left/right) pipelined multiply/accumulate unit that executes the dsp_op / A / B / C requests issued by ALU calculation sequencers.
- Returns the full 48-bit P result per lane.
- Sits between the ALU sequencers and the shared arithmetic resource. It models DSP48A1-style X/Z post-adder selection on two lanes in lockstep.

Parameters:
- AB_WIDTH, 18, signed width of A and B operands (Q2.16; 18'h10000 = 1.0).
- P_WIDTH, 48, signed width of C and P.
- OP_WIDTH, 9, width of dsp_op.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- dsp_op  in  9  operation word; both lanes execute the same op
- dsp_al  in  18  left A operand
- dsp_bl  in  18  left B operand
- dsp_cl  in  48  left C operand
- dsp_ar  in  18  right A operand
- dsp_br  in  18  right B operand
- dsp_cr  in  48  right C operand
- dsp_pl  out  48  left P result register
- dsp_pr  out  48  right P result register
- p_valid  out  1  one-cycle pulse when P was updated by a non-NOP op

Behaviour:
- Op encoding (globals.vh):
  - op[1:0] = X select: 0 zero, 1 `ALU_DSP_XIN_MULT (A*B), 2 P, 3 reserved (zero).
  - op[3:2] = Z select: 0 `ALU_DSP_ZIN_ZERO, 1 `ALU_DSP_ZIN_PIN (P), 2 `ALU_DSP_ZIN_CIN (C), 3 reserved (zero).
  - op[4] = `ALU_DSP_POSTADD_SUB (P = Z - X, else Z + X).
  - op[8:5] reserved, ignored.
  - `ALU_DSP_NOP = 9'h000.
- Pipeline: 3 register stages, identical per lane. A request is sampled at edge k.
  - Stage 1 (edge k): register A, B, C, op.
  - Stage 2 (edge k+1): M = A*B as a 36-bit signed product, sign-extended to 48 bits; C and op forwarded.
  - Stage 3 (edge k+2): P updated. P is visible from edge k+2 and p_valid is high for the cycle after edge k+2.
- Throughput: one op per cycle. Back-to-back issue is allowed with no bubbles.
- NOP behaviour: a NOP op (all bits zero) propagates as a bubble. At stage 3, P holds its value (clock-enable low) and p_valid = 0. X=0 with Z=0 and a nonzero op (e.g. sub only) clears P to 0.
- P feedback (X=P or Z=P) uses the P register value at stage 3. An op issued at k+1 therefore sees the result of the op issued at k (accumulation chains work at 1 op/cycle).
- X=P and Z=P together: P = P+P (or 0 for sub).
- Arithmetic: two's complement, 48-bit wrap-around. No saturation, no overflow flag.
- Lanes: left and right are fully independent datapaths sharing the op and the control pipeline.
- Reset (reset_n low, asynchronous, any time including mid-operation):
  - All stage registers clear, so in-flight ops are discarded.
  - dsp_pl = dsp_pr = 0, p_valid = 0.
  - The first request sampled after deassertion behaves normally.
- Inputs are not required to be held. Only the value at the sampling edge matters.

Test Plan:
- Multiply: op=XIN_MULT, al=18'h10000, bl=18'h08000 at edge k -> dsp_pl = 48'h0000_8000_0000 after edge k+2, dsp_pl[33:16] = 18'h08000, p_valid pulses once.
- Signed multiply and independent lanes: al=18'h30000 (-1.0), bl=18'h08000; ar=18'h04000, br=18'h04000 -> dsp_pl = 48'hFFFF_8000_0000, dsp_pr = 48'h0000_1000_0000.
- MADD: op=XIN_MULT|ZIN_CIN, al=bl=18'h10000, cl=48'h0000_0001_0000 -> dsp_pl = 48'h0001_0001_0000.
- Accumulate chain: 4 consecutive ops XIN_MULT|ZIN_PIN with al=18'h10000, bl=18'h04000, starting from P=0 -> P = 48'h40000000, 80000000, C0000000, 1_00000000 on successive cycles. Then one NOP -> P holds 48'h1_00000000 and p_valid = 0.
- Subtract: P=48'h1_0000_0000, op=XIN_MULT|ZIN_PIN|POSTADD_SUB, al=bl=18'h10000 -> P = 48'h0.
- Reset mid-pipe: issue 2 multiplies, pulse reset_n low between their stage-2 and stage-3 edges -> P = 0 and no p_valid. After release, a new multiply completes with 3-stage latency.
